// File: rtl/audio_clk_seq.sv
// audio_clk_seq
// -----------------------------------------------------------------------------
// Clock/reset sequencer for the 256*fs audio domain. It synchronises the
// release of the system reset and holds the codec in reset for a settling
// interval. It then free-runs the per-sample frame counter that produces the
// sample strobe, LRCK (fs) and BICK (64*fs).
//
// Sequence after rst is released (t0 = first rising edge with rst low):
//   edge t0+1                 : rst_sync falls
//   edge t0+2                 : IDLE -> SETTLE, codec_rst_n rises
//   edge t0+2+SETTLE_CYCLES   : SETTLE -> RUN, running rises, frame_ctr = 0
//   then one sample_strobe every 256 cycles, the first 255 cycles into RUN.
//
// Parameters:
//   SETTLE_CYCLES  cycles spent in SETTLE (1..65535, 0 behaves as 1)
//   MUTE_FRAMES    frames mute stays high after entering RUN (1..255),
//                  only used when AUDIO_CLK_SEQ_SOFTMUTE_EN is defined
//
// Build option:
//   AUDIO_CLK_SEQ_SOFTMUTE_EN  when defined, mute is released only after
//                              MUTE_FRAMES sample strobes in RUN; otherwise
//                              mute is simply the registered inverse of
//                              running.
//
// Ports:
//   clk_256fs      in   audio master clock, 256*fs
//   rst            in   asynchronous active-high reset from the system manager
//   rst_sync       out  reset for downstream logic (async assert, sync release)
//   codec_rst_n    out  active-low codec reset
//   running        out  high while in RUN
//   frame_ctr      out  [7:0] phase within the current sample frame
//   sample_strobe  out  one-cycle pulse per frame (frame_ctr == 255)
//   lrck           out  fs word clock (frame_ctr[7])
//   bick           out  64*fs bit clock (frame_ctr[1])
//   mute           out  mute request to the DSP/DAC path
//
// Handshake note: this block has no valid/ready interfaces. All outputs are
// plain registered levels or single-cycle pulses. sample_strobe is
// qualified only by running.
// -----------------------------------------------------------------------------
module audio_clk_seq #(
  parameter int SETTLE_CYCLES = 4096,
  parameter int MUTE_FRAMES   = 16
) (
  input  logic       clk_256fs,
  input  logic       rst,
  output logic       rst_sync,
  output logic       codec_rst_n,
  output logic       running,
  output logic [7:0] frame_ctr,
  output logic       sample_strobe,
  output logic       lrck,
  output logic       bick,
  output logic       mute
);

  // A settle length of 0 is treated as 1, so the counter always has at least
  // one bit and the terminal count is well defined.
  localparam int              S_EFF       = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam int              SCW         = $clog2(S_EFF + 1);
  localparam logic [SCW-1:0]  SETTLE_LAST = SCW'(S_EFF - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Reset synchroniser. Both flops are set directly by rst, so even a runt
  // pulse shorter than a clock period restarts the full two-edge release.
  // ---------------------------------------------------------------------------
  logic [1:0] sync_q;

  always_ff @(posedge clk_256fs or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], 1'b0};
    end
  end

  assign rst_sync = sync_q[1];

  // ---------------------------------------------------------------------------
  // Sequencer FSM and frame counter. All of this state is reset by rst_sync,
  // so rst reaches it only through the synchroniser's asynchronous set.
  // ---------------------------------------------------------------------------
  state_t         state;
  logic [SCW-1:0] settle_cnt;
  logic [7:0]     frame_nxt;

  // The derived outputs are computed from the next frame value. They are
  // registered in the same edge as frame_ctr, so all of them describe the
  // same phase in any given cycle.
  assign frame_nxt = frame_ctr + 8'd1;

  always_ff @(posedge clk_256fs or posedge rst_sync) begin
    if (rst_sync) begin
      state         <= IDLE;
      settle_cnt    <= '0;
      codec_rst_n   <= 1'b0;
      running       <= 1'b0;
      frame_ctr     <= 8'd0;
      sample_strobe <= 1'b0;
      lrck          <= 1'b0;
      bick          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state       <= SETTLE;
          settle_cnt  <= '0;
          codec_rst_n <= 1'b1;
        end
        SETTLE: begin
          settle_cnt <= settle_cnt + 1'b1;
          if (settle_cnt == SETTLE_LAST) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          frame_ctr     <= frame_nxt;
          sample_strobe <= (frame_nxt == 8'hFF);
          lrck          <= frame_nxt[7];
          bick          <= frame_nxt[1];
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Mute generation
  // ---------------------------------------------------------------------------
`ifdef AUDIO_CLK_SEQ_SOFTMUTE_EN
  localparam logic [7:0] MUTE_LAST = 8'(MUTE_FRAMES - 1);

  // Counts sample strobes while still muted. Mute drops on the edge that
  // follows the MUTE_FRAMES-th strobe. After that, the counter freezes.
  logic [7:0] strobe_cnt;

  always_ff @(posedge clk_256fs or posedge rst_sync) begin
    if (rst_sync) begin
      strobe_cnt <= 8'd0;
      mute       <= 1'b1;
    end else if (sample_strobe && mute) begin
      strobe_cnt <= strobe_cnt + 8'd1;
      if (strobe_cnt == MUTE_LAST) begin
        mute <= 1'b0;
      end
    end
  end
`else
  // True on the edge that enters RUN and on every edge within RUN. Registering
  // its inverse makes mute fall in the same cycle that running rises.
  logic run_next;
  logic unused_mute_cfg;

  assign run_next        = (state == RUN) || ((state == SETTLE) && (settle_cnt == SETTLE_LAST));
  assign unused_mute_cfg = ^8'(MUTE_FRAMES);

  always_ff @(posedge clk_256fs or posedge rst_sync) begin
    if (rst_sync) begin
      mute <= 1'b1;
    end else begin
      mute <= ~run_next;
    end
  end
`endif

endmodule

// File: tb/tb_audio_clk_seq.sv
// tb_audio_clk_seq
// -----------------------------------------------------------------------------
// Bench for audio_clk_seq. Two instances share clock and reset: one with
// SETTLE_CYCLES=8 and one with SETTLE_CYCLES=0, which must behave like 1.
// Both use MUTE_FRAMES=3.
//
// Reference model: each output is computed arithmetically from k, the number
// of rising edges since t0. t0 is the first rising edge that samples rst low.
// Every falling edge compares both instances against that model.
//
// Strobe scoreboard: when a release is issued, the edge numbers of every
// expected sample_strobe in the planned run are pushed into exp_q. A monitor
// pops one entry for each strobe the DUT shows. Any entry left over when reset
// is asserted again is reported.
//
// Mute expectation follows AUDIO_CLK_SEQ_SOFTMUTE_EN, the same macro used for
// the design build.
// -----------------------------------------------------------------------------
module tb_audio_clk_seq;

  localparam int SETTLE = 8;
  localparam int MF     = 3;

  // {rst_sync, codec_rst_n, running, sample_strobe, lrck, bick, mute, frame_ctr}
  localparam logic [14:0] RST_VEC = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};

  // ---------------------------------------------------------------------------
  // Clock and reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;

  initial begin
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------------------
  // DUTs
  // ---------------------------------------------------------------------------
  logic       a_rst_sync, a_codec_rst_n, a_running, a_strobe, a_lrck, a_bick, a_mute;
  logic [7:0] a_frame;
  logic       b_rst_sync, b_codec_rst_n, b_running, b_strobe, b_lrck, b_bick, b_mute;
  logic [7:0] b_frame;

  audio_clk_seq #(.SETTLE_CYCLES(SETTLE), .MUTE_FRAMES(MF)) dut (
    .clk_256fs     (clk),
    .rst           (rst),
    .rst_sync      (a_rst_sync),
    .codec_rst_n   (a_codec_rst_n),
    .running       (a_running),
    .frame_ctr     (a_frame),
    .sample_strobe (a_strobe),
    .lrck          (a_lrck),
    .bick          (a_bick),
    .mute          (a_mute)
  );

  audio_clk_seq #(.SETTLE_CYCLES(0), .MUTE_FRAMES(MF)) dut0 (
    .clk_256fs     (clk),
    .rst           (rst),
    .rst_sync      (b_rst_sync),
    .codec_rst_n   (b_codec_rst_n),
    .running       (b_running),
    .frame_ctr     (b_frame),
    .sample_strobe (b_strobe),
    .lrck          (b_lrck),
    .bick          (b_bick),
    .mute          (b_mute)
  );

  wire [14:0] a_vec = {a_rst_sync, a_codec_rst_n, a_running, a_strobe, a_lrck, a_bick, a_mute, a_frame};
  wire [14:0] b_vec = {b_rst_sync, b_codec_rst_n, b_running, b_strobe, b_lrck, b_bick, b_mute, b_frame};

  // ---------------------------------------------------------------------------
  // Bench state
  // ---------------------------------------------------------------------------
  int          e          = 0;  // rising edges seen so far
  int          t0         = 0;  // edge index of the first edge with rst low
  int          plan_len   = 0;  // planned edges after t0 before the next reset
  bit          waiting_t0 = 1'b0;
  int          n_cmp      = 0;
  int          n_bad      = 0;
  logic [31:0] exp_q[$];

  // ---------------------------------------------------------------------------
  // Reference model: outputs after edge t0+k for a given effective settle.
  // ---------------------------------------------------------------------------
  function automatic logic [14:0] model(input int s_eff, input int k);
    logic rs, cr, run, stb, lr, bk, mt;
    int   f;
    int   run_cycles;
    rs         = (k < 1);
    cr         = (k >= 2);
    run        = (k >= 2 + s_eff);
    run_cycles = run ? (k - 2 - s_eff) : 0;
    f          = run_cycles % 256;
    stb        = run && (f == 255);
    lr         = run && (f >= 128);
    bk         = run && ((f % 4) >= 2);
`ifdef AUDIO_CLK_SEQ_SOFTMUTE_EN
    mt         = !(run && (run_cycles >= 256 * MF));
`else
    mt         = !run;
`endif
    return {rs, cr, run, stb, lr, bk, mt, 8'(f)};
  endfunction

  task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, e);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Edge tracker. It finds t0 and pushes the expected strobe edges for the
  // planned run into the scoreboard.
  // ---------------------------------------------------------------------------
  always @(posedge clk) begin
    e++;
    if (waiting_t0 && (rst == 1'b0)) begin
      t0         = e;
      waiting_t0 = 1'b0;
      for (int s = t0 + 2 + SETTLE + 255; s <= t0 + plan_len; s += 256) begin
        exp_q.push_back(32'(s));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: per-cycle model comparison plus strobe scoreboard pops.
  // ---------------------------------------------------------------------------
  logic [14:0] mon_ea;
  logic [14:0] mon_eb;
  logic [31:0] mon_x;

  always @(negedge clk) begin
    if (rst || waiting_t0) begin
      mon_ea = RST_VEC;
      mon_eb = RST_VEC;
    end else begin
      mon_ea = model(SETTLE, e - t0);
      mon_eb = model(1, e - t0);
    end
    check("outputs_settle8", a_vec, mon_ea);
    check("outputs_settle0", b_vec, mon_eb);
    if (a_strobe) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL strobe_unexpected: got strobe at edge %0d expected none", e);
      end else begin
        mon_x = exp_q.pop_front();
        if (mon_x != 32'(e)) begin
          n_bad++;
          $display("FAIL strobe_edge: got edge %0d expected edge %0d", e, mon_x);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Release rst at a random point in the cycle, avoiding both clock edges.
  task automatic release_rst();
    int off;
    if (rst) begin
      @(negedge clk);
      off = $urandom_range(1, 8);
      if (off >= 5) off++;
      #(off) rst = 1'b0;
    end
  endtask

  task automatic wait_t0();
    int n;
    n = 0;
    while (waiting_t0 && (n < 6)) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (waiting_t0) begin
      n_bad++;
      $display("FAIL t0_timeout: got no edge with rst low after %0d cycles expected 1", n);
      waiting_t0 = 1'b0;
      t0         = e;
    end
  endtask

  // Called just after a falling edge. This asserts rst 1 ns later, checks the
  // asynchronous reset values before the next rising edge, and optionally
  // makes the pulse a 3 ns runt.
  task automatic assert_rst(input bit runt);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL strobe_missing: got %0d strobes outstanding expected 0 (next at edge %0d)",
               exp_q.size(), exp_q[0]);
    end
    exp_q.delete();
    rst        = 1'b1;
    waiting_t0 = 1'b1;
    #1;
    check("async_reset_settle8", a_vec, RST_VEC);
    check("async_reset_settle0", b_vec, RST_VEC);
    if (runt) begin
      #2 rst = 1'b0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int plans[6];
  bit runts[6];

  initial begin
    rst = 1'b0;
    #1;
    rst        = 1'b1;
    waiting_t0 = 1'b1;
    repeat (3) @(negedge clk);

    // Power-up run: at least four full frames, then reset at a random phase.
    plans[0] = 2 + SETTLE + 4 * 256 + $urandom_range(0, 255);
    runts[0] = 1'b0;
    // Reset lands while frame_ctr == 100.
    plans[1] = 2 + SETTLE + 4 * 256 + 100;
    runts[1] = 1'b0;
    // Runt pulse in RUN.
    plans[2] = $urandom_range(300, 1200);
    runts[2] = 1'b1;
    // Reset during IDLE/SETTLE or just after RUN is entered.
    plans[3] = $urandom_range(0, 2 + SETTLE + 2);
    runts[3] = 1'($urandom_range(0, 1));
    plans[4] = $urandom_range(800, 1300);
    runts[4] = 1'b1;
    plans[5] = $urandom_range(256, 600);
    runts[5] = 1'b0;

    for (int i = 0; i < 6; i++) begin
      plan_len = plans[i];
      release_rst();
      wait_t0();
      while (e < t0 + plan_len) @(negedge clk);
      assert_rst(runts[i]);
      if (!runts[i]) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test by 1 ms expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
